// File: rtl/irrigation_sequencer.sv
// irrigation_sequencer: turns irrigation requests into timed, mutually exclusive actuator commands
// with a min-on inlet valve, a qualified error input and a latched, acknowledged fault state.
module irrigation_sequencer #(
    parameter int CLK_DIV       = 50000000,
    parameter int SPRINKLE_TIME = 10,
    parameter int DRIP_TIME     = 20,
    parameter int VALVE_MIN_ON  = 3,
    parameter int ERR_CONFIRM   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ve_req,
    input  logic       bs_req,
    input  logic       vs_req,
    input  logic       al_in,
    input  logic       e_in,
    input  logic       ack,
    output logic       valve_on,
    output logic       sprinkler_on,
    output logic       drip_on,
    output logic       alarm_on,
    output logic       err_latched,
    output logic [2:0] state,
    output logic [7:0] secs_left
);
    typedef enum logic [2:0] {IDLE = 3'd0, SPRINKLE = 3'd1, DRIP = 3'd2, ALARM = 3'd3, FAULT = 3'd4} state_t;
    localparam int PW = $clog2(CLK_DIV);
    logic [PW-1:0] pre_q, pre_d;
    logic [7:0] err_q, err_d, vcnt_q, vcnt_d, secs_q, secs_d;
    state_t state_q, state_d;
    logic valve_q, valve_d, spr_q, drip_q, alarm_q, fault_q;
    logic tick, err_fire;
    assign tick     = pre_q == PW'(CLK_DIV - 1);
    assign pre_d    = tick ? '0 : pre_q + PW'(1);
    // error counter saturates at ERR_CONFIRM; the fault fires on the edge it gets there
    assign err_d    = !e_in ? 8'd0 : (tick && err_q < 8'(ERR_CONFIRM)) ? err_q + 8'd1 : err_q;
    assign err_fire = e_in && tick && err_q == 8'(ERR_CONFIRM - 1);
    always_comb begin
        state_d = state_q;
        secs_d  = secs_q;
        case (state_q)
            IDLE: begin
                if (al_in) state_d = ALARM;
                else if (bs_req) begin
                    state_d = SPRINKLE;
                    secs_d  = 8'(SPRINKLE_TIME);
                end else if (vs_req) begin
                    state_d = DRIP;
                    secs_d  = 8'(DRIP_TIME);
                end
            end
            SPRINKLE, DRIP: begin
                if (al_in) begin
                    state_d = ALARM;
                    secs_d  = 8'd0;
                end else if (tick) begin
                    secs_d  = secs_q - 8'd1;
                    state_d = secs_q == 8'd1 ? IDLE : state_q;
                end
            end
            ALARM:   state_d = al_in ? ALARM : IDLE;
            FAULT:   state_d = (ack && !e_in) ? IDLE : FAULT;
            default: begin
                state_d = IDLE;
                secs_d  = 8'd0;
            end
        endcase
        if (err_fire) begin
            state_d = FAULT;
            secs_d  = 8'd0;
        end
    end
    // the min-on window counts ticks from switch-on and is not restarted by ve_req toggling
    always_comb begin
        valve_d = valve_q;
        vcnt_d  = vcnt_q;
        if (!valve_q) begin
            valve_d = ve_req;
            vcnt_d  = 8'd0;
        end else begin
            vcnt_d  = (tick && vcnt_q < 8'(VALVE_MIN_ON)) ? vcnt_q + 8'd1 : vcnt_q;
            valve_d = !(vcnt_q >= 8'(VALVE_MIN_ON) && !ve_req);
        end
        if (state_d == FAULT) begin
            valve_d = 1'b0;
            vcnt_d  = 8'd0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            err_q   <= 8'd0;
            vcnt_q  <= 8'd0;
            secs_q  <= 8'd0;
            state_q <= IDLE;
            valve_q <= 1'b0;
            spr_q   <= 1'b0;
            drip_q  <= 1'b0;
            alarm_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            err_q   <= err_d;
            vcnt_q  <= vcnt_d;
            secs_q  <= secs_d;
            state_q <= state_d;
            valve_q <= valve_d;
            spr_q   <= state_d == SPRINKLE;
            drip_q  <= state_d == DRIP;
            alarm_q <= state_d == ALARM;
            fault_q <= state_d == FAULT;
        end
    end
    assign valve_on     = valve_q;
    assign sprinkler_on = spr_q;
    assign drip_on      = drip_q;
    assign alarm_on     = alarm_q;
    assign err_latched  = fault_q;
    assign state        = state_q;
    assign secs_left    = secs_q;
endmodule

// File: tb/tb_irrigation_sequencer.sv
// tb_irrigation_sequencer: directed scenarios plus randomized traffic checked each cycle
// against a behavioural model of the sequencer rules.
module tb_irrigation_sequencer;
    localparam int CD = 4, ST = 3, DT = 5, VM = 2, EC = 2;
    localparam int S_IDLE = 0, S_SPR = 1, S_DRIP = 2, S_ALM = 3, S_FLT = 4;
    logic clk = 1'b0;
    logic rst = 1'b1, ve_req = 1'b0, bs_req = 1'b0, vs_req = 1'b0, al_in = 1'b0, e_in = 1'b0, ack = 1'b0;
    logic valve_on, sprinkler_on, drip_on, alarm_on, err_latched;
    logic [2:0] state;
    logic [7:0] secs_left;
    int n_chk = 0, n_fail = 0;
    int m_state = 0, m_secs = 0, m_cyc = 0, m_ecnt = 0, m_vticks = 0;
    bit m_valve = 0;
    always #5 clk = ~clk;
    irrigation_sequencer #(.CLK_DIV(CD), .SPRINKLE_TIME(ST), .DRIP_TIME(DT), .VALVE_MIN_ON(VM), .ERR_CONFIRM(EC)) dut (
        .clk(clk), .rst(rst), .ve_req(ve_req), .bs_req(bs_req), .vs_req(vs_req), .al_in(al_in),
        .e_in(e_in), .ack(ack), .valve_on(valve_on), .sprinkler_on(sprinkler_on), .drip_on(drip_on),
        .alarm_on(alarm_on), .err_latched(err_latched), .state(state), .secs_left(secs_left)
    );
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // one clock edge of the reference: ticks are every CD-th cycle counted from reset release
    task automatic model_step();
        bit tk, fire;
        int ns, nsecs;
        if (rst) begin
            m_state = S_IDLE; m_secs = 0; m_cyc = 0; m_ecnt = 0; m_vticks = 0; m_valve = 0;
            return;
        end
        tk = (m_cyc % CD) == CD - 1;
        m_cyc++;
        fire = e_in && tk && (m_ecnt + 1 >= EC);
        m_ecnt = !e_in ? 0 : tk ? ((m_ecnt + 1 > EC) ? EC : m_ecnt + 1) : m_ecnt;
        ns = m_state; nsecs = m_secs;
        if (m_state == S_IDLE) begin
            if (al_in) ns = S_ALM;
            else if (bs_req) begin ns = S_SPR; nsecs = ST; end
            else if (vs_req) begin ns = S_DRIP; nsecs = DT; end
        end else if (m_state == S_SPR || m_state == S_DRIP) begin
            if (al_in) begin ns = S_ALM; nsecs = 0; end
            else if (tk) begin
                nsecs = m_secs - 1;
                if (nsecs == 0) ns = S_IDLE;
            end
        end else if (m_state == S_ALM) begin
            if (!al_in) ns = S_IDLE;
        end else if (ack && !e_in) ns = S_IDLE;
        if (fire) begin ns = S_FLT; nsecs = 0; end
        if (ns == S_FLT) begin
            m_valve = 0; m_vticks = 0;
        end else if (!m_valve) begin
            m_valve = ve_req; m_vticks = 0;
        end else begin
            if (m_vticks >= VM && !ve_req) m_valve = 0;
            if (tk) m_vticks++;
        end
        m_state = ns; m_secs = nsecs;
    endtask
    task automatic cyc(input logic r, input logic ve, input logic bs, input logic vs, input logic al, input logic e, input logic ak);
        rst = r; ve_req = ve; bs_req = bs; vs_req = vs; al_in = al; e_in = e; ack = ak;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("outputs", {state, secs_left, valve_on, sprinkler_on, drip_on, alarm_on, err_latched},
              {3'(m_state), 8'(m_secs), m_valve, m_state == S_SPR, m_state == S_DRIP, m_state == S_ALM, m_state == S_FLT});
        check("mutex", 16'(sprinkler_on & drip_on), 16'd0);
    endtask
    initial begin
        logic r, ve, bs, vs, al, e, ak;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 1, 1, 1, 1, 1);
            check("rst_state", 16'(state), 16'd0);
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0);
        check("post_rst_idle", 16'(state), 16'd0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        check("spr_entry", {8'(state), secs_left}, {8'd1, 8'd3});
        for (int i = 0; i < 14; i++) cyc(0, 0, 0, 0, 0, 0, 0);
        check("spr_done", {8'(state), secs_left}, 16'd0);
        cyc(0, 0, 1, 1, 0, 0, 0);
        check("both_spr_first", 16'(state), 16'd1);
        for (int i = 0; i < 14; i++) cyc(0, 0, 0, 1, 0, 0, 0);
        check("drip_follows", 16'(state), 16'd2);
        for (int i = 0; i < 40 && !(m_state == S_DRIP && m_secs == 3); i++) cyc(0, 0, 0, 0, 0, 0, 0);
        check("drip_at_3", {8'(state), secs_left}, {8'd2, 8'd3});
        cyc(0, 0, 0, 0, 1, 0, 0);
        check("alarm_abort", {8'(state), secs_left, 5'b0, alarm_on, drip_on, err_latched}, {8'd3, 8'd0, 8'b100});
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("alarm_exit", 16'(state), 16'd0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        check("valve_rise", 16'(valve_on), 16'd1);
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, 0, 0, 0);
        check("valve_minon_end", 16'(valve_on), 16'd0);
        for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 0, 0, 0);
        check("valve_held", 16'(valve_on), 16'd1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("valve_fall", 16'(valve_on), 16'd0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("one_tick_err", 16'(err_latched), 16'd0);
        for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0, 0, 1, 0);
        check("fault", {8'(state), 3'b0, err_latched, valve_on, sprinkler_on, drip_on, alarm_on}, {8'd4, 8'b10000});
        cyc(0, 0, 0, 0, 0, 1, 1);
        check("ack_ignored", 16'(state), 16'd4);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("ack_clear", {8'(state), 7'b0, err_latched}, 16'd0);
        r = 0; ve = 0; bs = 0; vs = 0; al = 0; e = 0; ak = 0;
        for (int i = 0; i < 5000; i++) begin
            r  = ($urandom_range(699) == 0);
            if ($urandom_range(7) == 0) ve = ~ve;
            bs = ($urandom_range(14) == 0);
            vs = ($urandom_range(14) == 0);
            if (al ? $urandom_range(9) == 0 : $urandom_range(79) == 0) al = ~al;
            if (e ? $urandom_range(14) == 0 : $urandom_range(59) == 0) e = ~e;
            ak = ($urandom_range(9) == 0);
            cyc(r, ve, bs, vs, al, e, ak);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/irrigation_sequencer.md
Name: irrigation_sequencer

Overview:
- Sequential actuator stage placed directly downstream of the combinational irrigation decision logic.
- Consumes its request and status signals (inlet valve, sprinkler, drip, alarm, error) and converts them into timed, mutually exclusive actuator commands.
- Adds an anti-chatter minimum on-time for the inlet valve and a latched, acknowledged fault state.
- Exports state and a seconds countdown for the display stage.

Parameters:
- CLK_DIV, 50000000: clock cycles per one-second tick; legal range ≥2.
- SPRINKLE_TIME, 10: sprinkler cycle length in ticks; 1..255.
- DRIP_TIME, 20: drip cycle length in ticks; 1..255.
- VALVE_MIN_ON, 3: minimum inlet-valve on-time in ticks; 1..255.
- ERR_CONFIRM, 2: ticks the error input must persist before a fault is latched; 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ve_req  in  1  inlet valve request
- bs_req  in  1  sprinkler request
- vs_req  in  1  drip request
- al_in  in  1  alarm (tank level critical)
- e_in  in  1  sensor inconsistency error
- ack  in  1  operator fault acknowledge, level sampled
- valve_on  out  1  inlet valve drive
- sprinkler_on  out  1  sprinkler pump drive
- drip_on  out  1  drip valve drive
- alarm_on  out  1  alarm indicator
- err_latched  out  1  fault indicator
- state  out  3  IDLE=0, SPRINKLE=1, DRIP=2, ALARM=3, FAULT=4
- secs_left  out  8  remaining ticks of the active cycle, 0 otherwise

Behaviour:
Interface and outputs
- Interface is decided: one clock `clk`; reset `rst` is synchronous and active-high.
- All outputs are registered.
- While rst is high, every output is 0 and state is IDLE. The prescaler, error qualifier and valve counters all clear to 0.
- Reset wins over every other input at the same edge. Reset mid-cycle aborts the cycle with no residual state.

Tick generation
- Prescaler counts 0..CLK_DIV-1.
- tick is an internal 1-cycle pulse asserted when count == CLK_DIV-1; the counter then wraps to 0.
- The first tick after reset occurs CLK_DIV cycles after rst deasserts.

Error qualifier
- Counter increments on each tick while e_in=1.
- Any clock with e_in=0 clears the counter.
- When the counter reaches ERR_CONFIRM, the FSM enters FAULT from any state on that same edge.

FSM transitions (priority: FAULT > ALARM > SPRINKLE > DRIP)
- IDLE:
  - al_in -> ALARM.
  - else bs_req -> SPRINKLE with secs_left=SPRINKLE_TIME.
  - else vs_req -> DRIP with secs_left=DRIP_TIME.
- SPRINKLE / DRIP:
  - sprinkler_on (resp. drip_on) = 1.
  - Each tick decrements secs_left.
  - A tick with secs_left==1 -> IDLE with secs_left=0. Active duration is therefore exactly N ticks (±1 tick of alignment on entry).
  - Dropping the request mid-cycle does NOT abort the cycle.
  - al_in=1 aborts to ALARM with secs_left=0.
- ALARM:
  - alarm_on=1; sprinkler and drip are off.
  - al_in=0 -> IDLE.
- FAULT:
  - err_latched=1; all actuators off, including the valve, which overrides its min-on time.
  - Exit to IDLE only when ack=1 and e_in=0 in the same cycle.
  - ack while e_in=1 is ignored.
- Mutual exclusion: sprinkler_on and drip_on are never both 1.
- Outputs reflect the new state on the clock after the transition edge; there is 1-cycle latency from input to output.

Inlet valve (independent of the FSM except in FAULT)
- valve_on rises on the cycle after ve_req=1.
- Once on, valve_on holds for at least VALVE_MIN_ON ticks.
- After that it falls on the cycle after ve_req=0.
- If ve_req toggles during the min-on window, the window does not restart.
- Valve operation is allowed in IDLE, SPRINKLE, DRIP and ALARM.

Simultaneous events
- al_in together with bs_req in IDLE -> ALARM.
- Tick with secs_left==1 at the same edge as al_in -> ALARM.
- Qualified error at the same edge as anything else -> FAULT.

Test Plan (CLK_DIV=4, SPRINKLE_TIME=3, DRIP_TIME=5, VALVE_MIN_ON=2, ERR_CONFIRM=2):
1. Reset held 3 cycles with all inputs high -> all outputs 0 and state=0 throughout. After release with inputs low, state stays 0.
2. bs_req pulsed 1 cycle in IDLE -> state=1 and sprinkler_on=1 with secs_left=3, counting 3,2,1, then state=0 and secs_left=0 after 3 ticks (~12 cycles). drip_on stays 0.
3. bs_req=vs_req=1 -> sprinkler cycle first. Once it ends, if vs_req is still high, a drip cycle starts with secs_left=5.
4. In DRIP at secs_left=3, raise al_in -> next cycle state=3, alarm_on=1, drip_on=0, secs_left=0. Drop al_in -> state=0.
5. ve_req high 1 cycle -> valve_on=1 for 2 ticks (8 cycles ±tick alignment) then 0. ve_req held high 20 cycles -> valve_on high until 1 cycle after ve_req falls.
6. e_in high 1 tick then low -> no fault. e_in high 2 ticks -> state=4, err_latched=1, all drives 0. ack with e_in=1 -> still FAULT. ack with e_in=0 -> state=0, err_latched=0.
